// File: rtl/sap_pkg.sv
// Shared types for the SAP control sequencer: ALU operations, opcodes, T-states and strobe bundle.
package sap_pkg;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5
    } alu_op_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_AND = 4'h9,
        OP_OR  = 4'hA,
        OP_XOR = 4'hB,
        OP_JN  = 4'hC,
        OP_RSV = 4'hD,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_HALT = 3'd6
    } ctrl_state_e;

    typedef struct packed {
        logic pc_oe;
        logic pc_inc;
        logic pc_load;
        logic mar_load;
        logic ram_oe;
        logic ram_we;
        logic ir_load;
        logic ir_oe;
        logic a_load;
        logic a_oe;
        logic b_load;
        logic alu_oe;
        logic out_load;
    } strobes_t;

    function automatic alu_op_e alu_op_of(input opcode_e op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/sap_flags_reg.sv
// Z/N/C/V flags register: async active-low clear, loads only when we is high.
module sap_flags_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'b0000;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sap_ctrl_seq.sv
// SAP control sequencer: steps T-states, decodes the opcode and drives the datapath strobes.
module sap_ctrl_seq
    import sap_pkg::*;
#(
    parameter int N   = 8,
    parameter int OPW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step_en,
    input  logic [N-1:0] ir,
    input  logic         alu_z,
    input  logic         alu_n,
    input  logic         alu_c,
    input  logic         alu_v,
    output logic         pc_oe,
    output logic         pc_inc,
    output logic         pc_load,
    output logic         mar_load,
    output logic         ram_oe,
    output logic         ram_we,
    output logic         ir_load,
    output logic         ir_oe,
    output logic         a_load,
    output logic         a_oe,
    output logic         b_load,
    output logic         alu_oe,
    output logic [2:0]   alu_op,
    output logic         out_load,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_c,
    output logic         flag_v,
    output logic         halted
);

    ctrl_state_e state, state_nxt;
    opcode_e     opc;
    strobes_t    strb_raw, strb;
    alu_op_e     op_raw;
    logic        we_raw;
    logic [3:0]  flags;

    assign opc = opcode_e'(ir[N-1 -: OPW]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (step_en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        strb_raw  = '0;
        op_raw    = ALU_PASS;
        we_raw    = 1'b0;
        state_nxt = state;
        unique case (state)
            ST_IDLE: state_nxt = ST_T0;
            ST_T0: begin
                strb_raw.pc_oe    = 1'b1;
                strb_raw.mar_load = 1'b1;
                state_nxt         = ST_T1;
            end
            ST_T1: begin
                strb_raw.ram_oe  = 1'b1;
                strb_raw.ir_load = 1'b1;
                strb_raw.pc_inc  = 1'b1;
                state_nxt        = ST_T2;
            end
            ST_T2: begin
                state_nxt = ST_T0;
                case (opc)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        strb_raw.ir_oe    = 1'b1;
                        strb_raw.mar_load = 1'b1;
                        state_nxt         = ST_T3;
                    end
                    OP_LDI: begin
                        strb_raw.ir_oe  = 1'b1;
                        strb_raw.a_load = 1'b1;
                    end
                    OP_JMP: begin
                        strb_raw.ir_oe   = 1'b1;
                        strb_raw.pc_load = 1'b1;
                    end
                    // Conditional jumps read the registered flags from the last ALU op
                    OP_JC, OP_JZ, OP_JN: begin
                        if ((opc == OP_JC && flags[1]) || (opc == OP_JZ && flags[3]) ||
                            (opc == OP_JN && flags[2])) begin
                            strb_raw.ir_oe   = 1'b1;
                            strb_raw.pc_load = 1'b1;
                        end
                    end
                    OP_OUT: begin
                        strb_raw.a_oe     = 1'b1;
                        strb_raw.out_load = 1'b1;
                    end
                    OP_HLT:  state_nxt = ST_HALT;
                    default: ;
                endcase
            end
            ST_T3: begin
                state_nxt = ST_T0;
                case (opc)
                    OP_LDA: begin
                        strb_raw.ram_oe = 1'b1;
                        strb_raw.a_load = 1'b1;
                    end
                    OP_STA: begin
                        strb_raw.a_oe   = 1'b1;
                        strb_raw.ram_we = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        strb_raw.ram_oe = 1'b1;
                        strb_raw.b_load = 1'b1;
                        state_nxt       = ST_T4;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                state_nxt       = ST_T0;
                strb_raw.alu_oe = 1'b1;
                strb_raw.a_load = 1'b1;
                op_raw          = alu_op_of(opc);
                we_raw          = 1'b1;
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A low step_en freezes the sequencer and silences every strobe
    assign strb   = step_en ? strb_raw : '0;
    assign alu_op = step_en ? op_raw : ALU_PASS;

    sap_flags_reg u_flags (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_raw & step_en),
        .d     ({alu_z, alu_n, alu_c, alu_v}),
        .q     (flags)
    );

    assign {flag_z, flag_n, flag_c, flag_v} = flags;
    assign halted = (state == ST_HALT);

    assign pc_oe    = strb.pc_oe;
    assign pc_inc   = strb.pc_inc;
    assign pc_load  = strb.pc_load;
    assign mar_load = strb.mar_load;
    assign ram_oe   = strb.ram_oe;
    assign ram_we   = strb.ram_we;
    assign ir_load  = strb.ir_load;
    assign ir_oe    = strb.ir_oe;
    assign a_load   = strb.a_load;
    assign a_oe     = strb.a_oe;
    assign b_load   = strb.b_load;
    assign alu_oe   = strb.alu_oe;
    assign out_load = strb.out_load;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Directed vector bench for sap_ctrl_seq: one table row per clock cycle plus reset/halt sequences.
module tb_sap_ctrl_seq;
    import sap_pkg::*;

    localparam logic [12:0] PCOE  = 13'h1000, PCINC = 13'h0800, PCLD  = 13'h0400,
                            MARLD = 13'h0200, RAMOE = 13'h0100, RAMWE = 13'h0080,
                            IRLD  = 13'h0040, IROE  = 13'h0020, ALD   = 13'h0010,
                            AOE   = 13'h0008, BLD   = 13'h0004, ALUOE = 13'h0002,
                            OUTLD = 13'h0001;
    localparam logic [4:0]  F0 = 5'b00000, FC = 5'b00010, FZC = 5'b01010,
                            FN = 5'b00100, FV = 5'b00001, HV = 5'b10001;

    typedef struct packed {
        logic        en;
        logic [7:0]  ir_v;
        logic [3:0]  alu_f;
        logic [12:0] strb;
        alu_op_e     op;
        logic [4:0]  stat;
    } vec_t;

    logic       clk, rst_n, step_en;
    logic [7:0] ir;
    logic       alu_z, alu_n, alu_c, alu_v;
    logic       pc_oe, pc_inc, pc_load, mar_load, ram_oe, ram_we, ir_load, ir_oe;
    logic       a_load, a_oe, b_load, alu_oe, out_load;
    logic [2:0] alu_op;
    logic       flag_z, flag_n, flag_c, flag_v, halted;
    logic [12:0] strb;
    logic [4:0]  stat;

    int n_vec  = 0;
    int n_fail = 0;
    vec_t vq[$];

    sap_ctrl_seq dut (
        .clk(clk), .rst_n(rst_n), .step_en(step_en), .ir(ir),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
        .pc_oe(pc_oe), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
        .ram_oe(ram_oe), .ram_we(ram_we), .ir_load(ir_load), .ir_oe(ir_oe),
        .a_load(a_load), .a_oe(a_oe), .b_load(b_load), .alu_oe(alu_oe),
        .alu_op(alu_op), .out_load(out_load),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
        .halted(halted)
    );

    assign strb = {pc_oe, pc_inc, pc_load, mar_load, ram_oe, ram_we, ir_load, ir_oe,
                   a_load, a_oe, b_load, alu_oe, out_load};
    assign stat = {halted, flag_z, flag_n, flag_c, flag_v};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic [7:0] ir_v, input logic [3:0] alu_f,
                       input logic [12:0] s, input alu_op_e op, input logic [4:0] st);
        vq.push_back('{en, ir_v, alu_f, s, op, st});
    endtask

    task automatic drive(input logic en, input logic [7:0] ir_v, input logic [3:0] alu_f);
        step_en = en;
        ir      = ir_v;
        {alu_z, alu_n, alu_c, alu_v} = alu_f;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 8'h00, 4'h0);

        // ADD 14 with carry out; flags ignored outside T4 (alu inputs held at all-ones)
        add(1, 8'h2E, 4'hF, 13'h0,              ALU_PASS, F0);
        add(1, 8'h2E, 4'hF, PCOE|MARLD,         ALU_PASS, F0);
        add(1, 8'h2E, 4'hF, RAMOE|IRLD|PCINC,   ALU_PASS, F0);
        add(1, 8'h2E, 4'hF, IROE|MARLD,         ALU_PASS, F0);
        add(1, 8'h2E, 4'hF, RAMOE|BLD,          ALU_PASS, F0);
        add(1, 8'h2E, 4'b0010, ALUOE|ALD,       ALU_ADD,  F0);
        // SUB 15 giving zero, then JZ taken
        add(1, 8'h3F, 4'hF, PCOE|MARLD,         ALU_PASS, FC);
        add(1, 8'h3F, 4'hF, RAMOE|IRLD|PCINC,   ALU_PASS, FC);
        add(1, 8'h3F, 4'hF, IROE|MARLD,         ALU_PASS, FC);
        add(1, 8'h3F, 4'hF, RAMOE|BLD,          ALU_PASS, FC);
        add(1, 8'h3F, 4'b1010, ALUOE|ALD,       ALU_SUB,  FC);
        add(1, 8'h83, 4'hF, PCOE|MARLD,         ALU_PASS, FZC);
        add(1, 8'h83, 4'hF, RAMOE|IRLD|PCINC,   ALU_PASS, FZC);
        add(1, 8'h83, 4'hF, IROE|PCLD,          ALU_PASS, FZC);
        // ADD giving negative: clears Z and C, sets N
        add(1, 8'h2E, 4'hF, PCOE|MARLD,         ALU_PASS, FZC);
        add(1, 8'h2E, 4'hF, RAMOE|IRLD|PCINC,   ALU_PASS, FZC);
        add(1, 8'h2E, 4'hF, IROE|MARLD,         ALU_PASS, FZC);
        add(1, 8'h2E, 4'hF, RAMOE|BLD,          ALU_PASS, FZC);
        add(1, 8'h2E, 4'b0100, ALUOE|ALD,       ALU_ADD,  FZC);
        // JZ not taken, JN taken, JC not taken
        add(1, 8'h83, 4'hF, PCOE|MARLD,         ALU_PASS, FN);
        add(1, 8'h83, 4'hF, RAMOE|IRLD|PCINC,   ALU_PASS, FN);
        add(1, 8'h83, 4'hF, 13'h0,              ALU_PASS, FN);
        add(1, 8'hC5, 4'hF, PCOE|MARLD,         ALU_PASS, FN);
        add(1, 8'hC5, 4'hF, RAMOE|IRLD|PCINC,   ALU_PASS, FN);
        add(1, 8'hC5, 4'hF, IROE|PCLD,          ALU_PASS, FN);
        add(1, 8'h75, 4'hF, PCOE|MARLD,         ALU_PASS, FN);
        add(1, 8'h75, 4'hF, RAMOE|IRLD|PCINC,   ALU_PASS, FN);
        add(1, 8'h75, 4'hF, 13'h0,              ALU_PASS, FN);
        // LDA with step_en 1,0,0,1 around T2
        add(1, 8'h1A, 4'hF, PCOE|MARLD,         ALU_PASS, FN);
        add(1, 8'h1A, 4'hF, RAMOE|IRLD|PCINC,   ALU_PASS, FN);
        add(0, 8'h1A, 4'hF, 13'h0,              ALU_PASS, FN);
        add(0, 8'h1A, 4'hF, 13'h0,              ALU_PASS, FN);
        add(1, 8'h1A, 4'hF, IROE|MARLD,         ALU_PASS, FN);
        add(1, 8'h1A, 4'hF, RAMOE|ALD,          ALU_PASS, FN);
        // STA, LDI, OUT
        add(1, 8'h47, 4'hF, PCOE|MARLD,         ALU_PASS, FN);
        add(1, 8'h47, 4'hF, RAMOE|IRLD|PCINC,   ALU_PASS, FN);
        add(1, 8'h47, 4'hF, IROE|MARLD,         ALU_PASS, FN);
        add(1, 8'h47, 4'hF, AOE|RAMWE,          ALU_PASS, FN);
        add(1, 8'h59, 4'hF, PCOE|MARLD,         ALU_PASS, FN);
        add(1, 8'h59, 4'hF, RAMOE|IRLD|PCINC,   ALU_PASS, FN);
        add(1, 8'h59, 4'hF, IROE|ALD,           ALU_PASS, FN);
        add(1, 8'hE0, 4'hF, PCOE|MARLD,         ALU_PASS, FN);
        add(1, 8'hE0, 4'hF, RAMOE|IRLD|PCINC,   ALU_PASS, FN);
        add(1, 8'hE0, 4'hF, AOE|OUTLD,          ALU_PASS, FN);
        // AND stalled in T4: no flag write while step_en=0
        add(1, 8'h91, 4'hF, PCOE|MARLD,         ALU_PASS, FN);
        add(1, 8'h91, 4'hF, RAMOE|IRLD|PCINC,   ALU_PASS, FN);
        add(1, 8'h91, 4'hF, IROE|MARLD,         ALU_PASS, FN);
        add(1, 8'h91, 4'hF, RAMOE|BLD,          ALU_PASS, FN);
        add(0, 8'h91, 4'b1000, 13'h0,           ALU_PASS, FN);
        add(1, 8'h91, 4'b0001, ALUOE|ALD,       ALU_AND,  FN);
        // Reserved opcode D runs as NOP, then HLT
        add(1, 8'hD0, 4'hF, PCOE|MARLD,         ALU_PASS, FV);
        add(1, 8'hD0, 4'hF, RAMOE|IRLD|PCINC,   ALU_PASS, FV);
        add(1, 8'hD0, 4'hF, 13'h0,              ALU_PASS, FV);
        add(1, 8'hF0, 4'hF, PCOE|MARLD,         ALU_PASS, FV);
        add(1, 8'hF0, 4'hF, RAMOE|IRLD|PCINC,   ALU_PASS, FV);
        add(1, 8'hF0, 4'hF, 13'h0,              ALU_PASS, FV);
        add(1, 8'hF0, 4'hF, 13'h0,              ALU_PASS, HV);

        repeat (2) @(negedge clk);
        #1;
        chk("reset strobes", 32'(strb), 32'h0);
        chk("reset alu_op", 32'(alu_op), 32'(ALU_PASS));
        chk("reset status", 32'(stat), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].ir_v, vq[i].alu_f);
            #1;
            chk($sformatf("vec%0d strobes", i), 32'(strb), 32'(vq[i].strb));
            chk($sformatf("vec%0d alu_op", i), 32'(alu_op), 32'(vq[i].op));
            chk($sformatf("vec%0d status", i), 32'(stat), 32'(vq[i].stat));
            @(negedge clk);
        end

        // HALT is sticky regardless of step_en or ir
        for (int k = 0; k < 20; k++) begin
            drive(1'(k % 3 != 0), 8'(k * 37), 4'(k));
            #1;
            chk($sformatf("halt%0d strobes", k), 32'(strb), 32'h0);
            chk($sformatf("halt%0d halted", k), 32'(halted), 32'h1);
            @(negedge clk);
        end

        // Reset out of HALT, set C via ADD, then reset asynchronously during LDA T3
        rst_n = 1'b0;
        #1;
        chk("halt reset halted", 32'(halted), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h2E, 4'b0010);
        repeat (6) @(negedge clk);
        #1;
        chk("seq flag_c", 32'(stat), 32'(FC));
        chk("seq T0", 32'(strb), 32'(PCOE|MARLD));
        drive(1'b1, 8'h1A, 4'hF);
        repeat (3) @(negedge clk);
        #1;
        chk("seq LDA T3", 32'(strb), 32'(RAMOE|ALD));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst strobes", 32'(strb), 32'h0);
        chk("async rst status", 32'(stat), 32'h0);
        chk("async rst alu_op", 32'(alu_op), 32'(ALU_PASS));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post rst IDLE", 32'(strb), 32'h0);
        @(negedge clk);
        #1;
        chk("post rst T0", 32'(strb), 32'(PCOE|MARLD));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
